sr_ignition_trigger: RTL and testbench

Front-end detector that drives the ignition controller's trigger inputs. Each clock-enable sample it:
- estimates SR phase-locking value (PLV) from per-sample cos/sin of the phase difference;
- tracks a beta-band amplitude envelope with a hysteretic quiet detector;
- qualifies the combined condition through a small state machine.

Outputs are coherence_out and beta_quiet for the controller, plus a one-sample trigger pulse. The controller's ignition_active is fed back so that re-arming is locked out while an event runs.

---
 rtl/sr_ignition_trigger.sv | 208 ++++++++++++++++++++
 tb/tb_sr_ignition_trigger.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ignition_trigger.sv
// rtl/sr_ignition_trigger.sv - SR phase-locking / beta-quiet ignition trigger detector
// Optional SR_TRIG_STATS_EN adds saturating trig_count / abort_count outputs.
module sr_ignition_trigger #(
  parameter int WIDTH      = 18,
  parameter int FRAC       = 14,
  parameter int PLV_SHIFT  = 4,
  parameter int BETA_SHIFT = 5,
  parameter int HOLD_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] cos_dphi,
  input  logic signed [WIDTH-1:0] sin_dphi,
  input  logic signed [WIDTH-1:0] beta_in,
  input  logic [WIDTH-1:0]        quiet_thresh,
  input  logic [WIDTH-1:0]        quiet_hyst,
  input  logic [WIDTH-1:0]        coh_thresh,
  input  logic [HOLD_W-1:0]       qual_cycles,
  input  logic                    ignition_active,
  output logic [WIDTH-1:0]        coherence_out,
  output logic [WIDTH-1:0]        beta_env,
  output logic                    beta_quiet,
  output logic                    trigger,
  output logic [1:0]              trig_state
`ifdef SR_TRIG_STATS_EN
  ,
  output logic [15:0]             trig_count,
  output logic [15:0]             abort_count
`endif
);

  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0]    ONE      = EW'(1 << FRAC);
  localparam logic signed [WIDTH-1:0] BETA_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_FIRED   = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  logic signed [WIDTH-1:0] r_c_avg, r_s_avg;
  logic [WIDTH-1:0]        r_coh, r_env;
  logic                    r_quiet, r_trigger;
  logic [HOLD_W-1:0]       r_quiet_cnt, r_qual_cnt;
  logic [2:0]              r_fire_cnt;
  state_t                  r_state;

  function automatic logic signed [EW-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // PLV path: leaky averages, then max + min/2 magnitude approximation
  logic signed [EW-1:0]    w_c_diff, w_s_diff, w_c_abs, w_s_abs;
  logic signed [EW-1:0]    w_mag_max, w_mag_min, w_mag;
  logic signed [WIDTH-1:0] w_c_next, w_s_next;
  logic [WIDTH-1:0]        w_coh_next;

  assign w_c_diff   = sext(cos_dphi) - sext(r_c_avg);
  assign w_s_diff   = sext(sin_dphi) - sext(r_s_avg);
  assign w_c_next   = WIDTH'(sext(r_c_avg) + (w_c_diff >>> PLV_SHIFT));
  assign w_s_next   = WIDTH'(sext(r_s_avg) + (w_s_diff >>> PLV_SHIFT));
  assign w_c_abs    = w_c_next[WIDTH-1] ? -sext(w_c_next) : sext(w_c_next);
  assign w_s_abs    = w_s_next[WIDTH-1] ? -sext(w_s_next) : sext(w_s_next);
  assign w_mag_max  = (w_c_abs > w_s_abs) ? w_c_abs : w_s_abs;
  assign w_mag_min  = (w_c_abs > w_s_abs) ? w_s_abs : w_c_abs;
  assign w_mag      = w_mag_max + (w_mag_min >>> 1);
  assign w_coh_next = (w_mag > ONE) ? WIDTH'(ONE) : WIDTH'(w_mag);

  logic [WIDTH-1:0]     w_beta_abs, w_env_next;
  logic signed [EW-1:0] w_env_diff;

  always_comb begin
    if (beta_in == BETA_MIN)   w_beta_abs = {1'b0, {(WIDTH-1){1'b1}}};
    else if (beta_in[WIDTH-1]) w_beta_abs = $unsigned(-beta_in);
    else                       w_beta_abs = $unsigned(beta_in);
  end

  assign w_env_diff = $signed({2'b00, w_beta_abs}) - $signed({2'b00, r_env});
  assign w_env_next = WIDTH'($signed({2'b00, r_env}) + (w_env_diff >>> BETA_SHIFT));

  // Between the quiet threshold and threshold+hysteresis both flag and count hold
  logic [WIDTH:0]    w_release;
  logic              w_env_below, w_env_above, w_quiet_next;
  logic [HOLD_W-1:0] w_quiet_cnt_next;

  assign w_release   = {1'b0, quiet_thresh} + {1'b0, quiet_hyst};
  assign w_env_below = r_env < quiet_thresh;
  assign w_env_above = {1'b0, r_env} > w_release;

  always_comb begin
    w_quiet_cnt_next = r_quiet_cnt;
    w_quiet_next     = r_quiet;
    if (w_env_above) begin
      w_quiet_cnt_next = '0;
      w_quiet_next     = 1'b0;
    end else if (w_env_below) begin
      if (r_quiet_cnt != '1) w_quiet_cnt_next = r_quiet_cnt + 1'b1;
      if (w_quiet_cnt_next >= qual_cycles) w_quiet_next = 1'b1;
    end
  end

  logic              w_cond, w_fire, w_abort;
  state_t            w_state_next;
  logic [HOLD_W-1:0] w_qual_cnt_next;
  logic [2:0]        w_fire_cnt_next;

  assign w_cond = r_quiet && (r_coh >= coh_thresh);

  always_comb begin
    w_state_next    = r_state;
    w_qual_cnt_next = r_qual_cnt;
    w_fire_cnt_next = r_fire_cnt;
    w_fire          = 1'b0;
    w_abort         = 1'b0;
    if (clk_en) begin
      case (r_state)
        S_IDLE: begin
          if (w_cond) begin
            w_state_next    = S_QUALIFY;
            w_qual_cnt_next = HOLD_W'(1);
          end
        end
        S_QUALIFY: begin
          // A condition drop on the completing enable wins over firing
          if (!w_cond) begin
            w_state_next = S_IDLE;
            w_abort      = 1'b1;
          end else if (r_qual_cnt >= qual_cycles) begin
            w_state_next    = S_FIRED;
            w_fire_cnt_next = '0;
            w_fire          = 1'b1;
          end else begin
            w_qual_cnt_next = r_qual_cnt + 1'b1;
          end
        end
        S_FIRED: begin
          if (ignition_active) begin
            w_state_next = S_LOCKOUT;
          end else if (r_fire_cnt == 3'd7) begin
            w_state_next = S_IDLE;
            w_abort      = 1'b1;
          end else begin
            w_fire_cnt_next = r_fire_cnt + 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (!ignition_active) w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_avg     <= '0;
      r_s_avg     <= '0;
      r_coh       <= '0;
      r_env       <= '0;
      r_quiet     <= 1'b0;
      r_quiet_cnt <= '0;
      r_qual_cnt  <= '0;
      r_fire_cnt  <= '0;
      r_state     <= S_IDLE;
      r_trigger   <= 1'b0;
    end else begin
      r_trigger  <= w_fire;
      r_state    <= w_state_next;
      r_qual_cnt <= w_qual_cnt_next;
      r_fire_cnt <= w_fire_cnt_next;
      if (clk_en) begin
        r_c_avg     <= w_c_next;
        r_s_avg     <= w_s_next;
        r_coh       <= w_coh_next;
        r_env       <= w_env_next;
        r_quiet     <= w_quiet_next;
        r_quiet_cnt <= w_quiet_cnt_next;
      end
    end
  end

  assign coherence_out = r_coh;
  assign beta_env      = r_env;
  assign beta_quiet    = r_quiet;
  assign trigger       = r_trigger;
  assign trig_state    = r_state;

`ifdef SR_TRIG_STATS_EN
  logic [15:0] r_trig_count, r_abort_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_count  <= '0;
      r_abort_count <= '0;
    end else begin
      if (w_fire && r_trig_count != '1)   r_trig_count  <= r_trig_count + 1'b1;
      if (w_abort && r_abort_count != '1) r_abort_count <= r_abort_count + 1'b1;
    end
  end

  assign trig_count  = r_trig_count;
  assign abort_count = r_abort_count;
`endif

endmodule

// File: tb/tb_sr_ignition_trigger.sv
// tb/tb_sr_ignition_trigger.sv - randomized scoreboard bench for sr_ignition_trigger
module tb_sr_ignition_trigger;
  logic clk, rst, clk_en, ignition_active;
  logic signed [17:0] cos_dphi, sin_dphi, beta_in;
  logic [17:0] quiet_thresh, quiet_hyst, coh_thresh;
  logic [15:0] qual_cycles;
  logic [17:0] coherence_out, beta_env;
  logic beta_quiet, trigger;
  logic [1:0] trig_state;
`ifdef SR_TRIG_STATS_EN
  logic [15:0] trig_count, abort_count;
`endif

  sr_ignition_trigger dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .cos_dphi(cos_dphi), .sin_dphi(sin_dphi), .beta_in(beta_in),
    .quiet_thresh(quiet_thresh), .quiet_hyst(quiet_hyst), .coh_thresh(coh_thresh),
    .qual_cycles(qual_cycles), .ignition_active(ignition_active),
    .coherence_out(coherence_out), .beta_env(beta_env), .beta_quiet(beta_quiet),
    .trigger(trigger), .trig_state(trig_state)
`ifdef SR_TRIG_STATS_EN
    , .trig_count(trig_count), .abort_count(abort_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    int coh; int env; int quiet; int st; int trig; int tc; int ac;
  } exp_t;
  exp_t exp_q[$];

  int m_c, m_s, m_env, m_coh, m_quiet, m_qcnt, m_st, m_qn, m_fn, m_tc, m_ac;
  int qt, qh, ct, qc;
  int ign_pending, ign_delay, ign_hold, first_fire;

  function automatic int fdiv(int d, int sh);
    int q = 1 << sh;
    if (d >= 0) return d / q;
    return -((-d + q - 1) / q);
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_s = 0; m_env = 0; m_coh = 0; m_quiet = 0; m_qcnt = 0;
    m_st = 0; m_qn = 0; m_fn = 0; m_tc = 0; m_ac = 0;
  endtask

  // Reference: one sample of the detector, expressed with plain integer arithmetic
  task automatic model_step(int cv, int sv, int bv, int ign, output int fired);
    bit cond;
    int a, b, ab, mag;
    fired = 0;
    cond = (m_quiet != 0) && (m_coh >= ct);
    if (m_env > qt + qh) begin
      m_qcnt = 0; m_quiet = 0;
    end else if (m_env < qt) begin
      if (m_qcnt < 65535) m_qcnt++;
      if (m_qcnt >= qc) m_quiet = 1;
    end
    case (m_st)
      0: if (cond) begin m_st = 1; m_qn = 1; end
      1: begin
        if (!cond) begin m_st = 0; if (m_ac < 65535) m_ac++; end
        else if (m_qn >= qc) begin
          m_st = 2; m_fn = 0; fired = 1;
          if (m_tc < 65535) m_tc++;
        end else m_qn++;
      end
      2: begin
        if (ign != 0) m_st = 3;
        else begin
          m_fn++;
          if (m_fn >= 8) begin m_st = 0; if (m_ac < 65535) m_ac++; end
        end
      end
      default: if (ign == 0) m_st = 0;
    endcase
    m_c = m_c + fdiv(cv - m_c, 4);
    m_s = m_s + fdiv(sv - m_s, 4);
    a = iabs(m_c); b = iabs(m_s);
    mag = ((a > b) ? a : b) + ((a > b) ? b : a) / 2;
    m_coh = (mag > 16384) ? 16384 : mag;
    ab = (bv == -131072) ? 131071 : iabs(bv);
    m_env = m_env + fdiv(ab - m_env, 5);
    exp_q.push_back('{m_coh, m_env, m_quiet, m_st, fired, m_tc, m_ac});
  endtask

  task automatic issue(int cv, int sv, int bv);
    int fired;
    for (int k = 0; k < 3; k++) begin
      if ($urandom_range(0, 1) == 0) break;
      clk_en   = 1'b0;
      cos_dphi = 18'($urandom);
      sin_dphi = 18'($urandom);
      beta_in  = 18'($urandom);
      @(negedge clk);
    end
    if (ign_pending != 0) begin
      if (ign_delay == 0) begin ignition_active = 1'b1; ign_pending = 0; end
      else ign_delay--;
    end else if (ignition_active) begin
      if (ign_hold == 0) ignition_active = 1'b0;
      else ign_hold--;
    end
    clk_en       = 1'b1;
    cos_dphi     = 18'(cv);
    sin_dphi     = 18'(sv);
    beta_in      = 18'(bv);
    quiet_thresh = 18'(qt);
    quiet_hyst   = 18'(qh);
    coh_thresh   = 18'(ct);
    qual_cycles  = 16'(qc);
    model_step(cv, sv, bv, int'(ignition_active), fired);
    if (fired != 0) begin
      ign_pending = 1;
      ign_delay   = (first_fire != 0) ? 2 : int'($urandom_range(0, 11));
      ign_hold    = (first_fire != 0) ? 1000 : int'($urandom_range(0, 40));
      first_fire  = 0;
    end
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_coherence"}, int'(coherence_out), 0);
    chk({tag, "_beta_env"}, int'(beta_env), 0);
    chk({tag, "_beta_quiet"}, int'(beta_quiet), 0);
    chk({tag, "_trigger"}, int'(trigger), 0);
    chk({tag, "_state"}, int'(trig_state), 0);
`ifdef SR_TRIG_STATS_EN
    chk({tag, "_trig_count"}, int'(trig_count), 0);
    chk({tag, "_abort_count"}, int'(abort_count), 0);
`endif
  endtask

  // Monitor: each enable edge presents one result; other edges must not pulse trigger
  initial begin
    logic en_s, rst_s;
    exp_t e;
    forever begin
      @(posedge clk);
      en_s  = clk_en;
      rst_s = rst;
      #1;
      if (!rst_s) begin
        if (en_s) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_underflow: got empty queue, required one entry");
          end else begin
            e = exp_q.pop_front();
            chk("coherence_out", int'(coherence_out), e.coh);
            chk("beta_env", int'(beta_env), e.env);
            chk("beta_quiet", int'(beta_quiet), e.quiet);
            chk("trig_state", int'(trig_state), e.st);
            chk("trigger", int'(trigger), e.trig);
`ifdef SR_TRIG_STATS_EN
            chk("trig_count", int'(trig_count), e.tc);
            chk("abort_count", int'(abort_count), e.ac);
`endif
          end
        end else begin
          chk("trigger_no_enable", int'(trigger), 0);
        end
      end
    end
  end

  initial begin
    int nen, len, cmode, bmode, cv, sv, bv, mag, seg;
    rst = 1'b1; clk_en = 1'b0; ignition_active = 1'b0;
    cos_dphi = '0; sin_dphi = '0; beta_in = '0;
    quiet_thresh = '0; quiet_hyst = '0; coh_thresh = '0; qual_cycles = '0;
    ign_pending = 0; ign_delay = 0; ign_hold = 0; first_fire = 1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    qt = 2000; qh = 500; ct = 12288; qc = 100;
    for (int i = 0; i < 200; i++) issue(16384, 0, 0);
    chk("plv_settle", int'(coherence_out), 16369);
    chk("env_zero", int'(beta_env), 0);
    for (int i = 0; i < 1200; i++) issue(16384, 0, 0);

    nen = 0;
    seg = 0;
    while (nen < 7000) begin
      if (seg == 6) begin
        clk_en = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        exp_q.delete();
        ignition_active = 1'b0; ign_pending = 0;
        @(negedge clk);
        rst = 1'b0;
      end
      qt = int'($urandom_range(1000, 3000));
      qh = int'($urandom_range(0, 1000));
      ct = int'($urandom_range(9000, 14000));
      qc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 60));
      cmode = ($urandom_range(0, 3) != 0) ? 1 : 0;
      bmode = int'($urandom_range(0, 3));
      len = int'($urandom_range(40, 300));
      for (int i = 0; i < len; i++) begin
        if (cmode != 0) begin
          cv = 16384 - int'($urandom_range(0, 800));
          sv = int'($urandom_range(0, 3000)) - 1500;
        end else begin
          cv = int'($urandom_range(0, 32768)) - 16384;
          sv = int'($urandom_range(0, 32768)) - 16384;
        end
        if (bmode <= 1)      mag = int'($urandom_range(0, 300));
        else if (bmode == 2) mag = int'($urandom_range(500, 4000));
        else                 mag = int'($urandom_range(0, 131071));
        bv = ($urandom_range(0, 1) != 0) ? -mag : mag;
        if (bmode == 3 && $urandom_range(0, 39) == 0) bv = -131072;
        issue(cv, sv, bv);
      end
      nen += len;
      seg++;
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
